r2sdf_fft_ctrl: RTL
===================

Name: r2sdf_fft_ctrl

Overview:
Sequencer for the radix-2 single-delay-feedback FFT pipeline (N stages, 2^N points per frame).
- On a start_ip pulse it drives four kinds of control: input-sample framing, per-stage butterfly/pass-through select, per-stage twiddle ROM addresses and output valid/index.
- It lets the datapath run without local counters.
- It sits beside the fft datapath, and the frame source and result collector key off it.

Parameters:
- N, 4: log2 of FFT points; number of pipeline stages.
- STG_PIPE, 1: register stages per stage beyond its delay line (butterfly/twiddle-multiply pipe).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start_ip  in  1  frame start request; sampled only in IDLE.
- busy  out  1  high in RUN, DRAIN and DONE.
- in_valid  out  1  high while the datapath must take an input sample.
- stage_en  out  N  per-stage enable; bit s belongs to stage s.
- bf_sel  out  N  1 = butterfly mode, 0 = fill/pass-through mode; bit s belongs to stage s.
- tw_addr  out  N*(N-1)  per-stage twiddle ROM address; stage s occupies [s*(N-1) +: N-1].
- op_valid  out  1  datapath output sample valid.
- op_idx  out  N  result-array write index for the current output.
- frame_done  out  1  one-cycle pulse after the last output.

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, g=0, every output 0. Reset mid-frame aborts immediately; outputs are 0 from the following cycle.
- Global counter g (width = clog2(2^N + D_N + 1)) is 0 in the first cycle after start is accepted, and increments every cycle in RUN/DRAIN.
- Stage latency L_s = 2^(N-1-s) + STG_PIPE.
- Offset D_s = sum of L_k for k<s; D_N = total pipeline latency.
- Local counter cnt_s = (g - D_s) mod 2^N.
- FSM:
  - IDLE: start_ip=1 -> RUN.
  - RUN: g = 0 .. 2^N-1; at g = 2^N-1 -> DRAIN.
  - DRAIN: at g = D_N + 2^N - 1 -> DONE.
  - DONE: one cycle, frame_done=1 -> IDLE.
- start_ip outside IDLE is ignored, including in DONE.
- All outputs are registered; each value corresponds to the g of that cycle.
- in_valid = 1 exactly for g in [0, 2^N-1]; sample k is consumed at g = k.
- stage_en[s] = 1 for g in [D_s, D_s + L_s + 2^N - 1], which flushes the stage's delay line; 0 otherwise.
- bf_sel[s] = stage_en[s] & cnt_s[N-1-s].
- Twiddle address for stage s < N-1: {cnt_s[N-2-s:0], s zero bits} when stage_en[s] and bf_sel[s]=0, else 0. The last stage's field is always 0 (trivial twiddle).
- op_valid = 1 for g in [D_N, D_N + 2^N - 1].
- op_idx = bitrev_N(g - D_N) while op_valid, else 0.
- Example, N=4, STG_PIPE=1:
  - L = 9, 5, 3, 2; D = 0, 9, 14, 17; D_N = 19.
  - Outputs at g = 19..34; frame_done at g = 35.
- busy = (state != IDLE).

Optional Feature:
- Macro: R2SDF_CTRL_BITREV_EN.
- Defined: op_idx is the bit-reversed output count, so results land in natural frequency order.
- Undefined: op_idx = g - D_N (raw pipeline order); the collector reorders.
- All other outputs are identical in both builds.

Decomposition:
- Shared package r2sdf_pkg holds:
  - function stage_lat(s) returning L_s.
  - function stage_off(s) returning D_s.
  - function bitrev(x, N).
  - FSM state encoding: IDLE, RUN, DRAIN, DONE.
- One sub-module, r2sdf_stage_seq, generated per stage. From g it produces stage_en, bf_sel and its tw_addr slice, with parameters N, S, D_s and L_s.
- The top holds the FSM, g, in_valid and the output indexing.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles, then release with start_ip=0 -> all outputs 0, busy=0.
2. N=4: start_ip pulse in IDLE -> in_valid high exactly for g=0..15. bf_sel[0] is 0 for g=0..7 and 1 for g=8..15. tw_addr stage 0 is 0..7 at g=16..23.
3. Same frame -> op_valid high at g=19..34 with op_idx = 0, 8, 4, 12, 2, 10, ... 15. frame_done pulses only at g=35; busy falls on the next cycle.
4. start_ip asserted at g=5, g=25 and in the DONE cycle -> ignored, frame timing unchanged. start_ip on the first IDLE cycle after DONE -> new frame with g restarting at 0.
5. rst_n=0 at g=22 (DRAIN) -> next cycle all outputs 0, state IDLE; a subsequent start produces a full correct frame.
6. Build without R2SDF_CTRL_BITREV_EN -> op_idx = 0, 1, 2, ... 15 at g=19..34; other outputs bit-identical to scenario 3.

Source files
------------

// File: rtl/r2sdf_pkg.sv
// Shared definitions for the radix-2 SDF FFT sequencer: FSM encoding,
// per-stage latency/offset helpers and a bit-reverse helper.
package r2sdf_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Delay line of 2^(n-1-s) plus the butterfly/twiddle pipe registers.
  function automatic int stage_lat(input int s, input int n, input int pipe);
    return (1 << (n - 1 - s)) + pipe;
  endfunction

  function automatic int stage_off(input int s, input int n, input int pipe);
    int d;
    d = 0;
    for (int k = 0; k < s; k++) d += stage_lat(k, n, pipe);
    return d;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] x, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < n) r[i] = x[n-1-i];
    return r;
  endfunction

endpackage

// File: rtl/r2sdf_stage_seq.sv
// Per-stage control for one SDF stage: enable window, butterfly select and
// twiddle address, all registered from the look-ahead global count.
module r2sdf_stage_seq #(
  parameter int N  = 4,
  parameter int S  = 0,
  parameter int D  = 0,
  parameter int L  = 9,
  parameter int GW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic [GW-1:0] g,
  output logic          stage_en,
  output logic          bf_sel,
  output logic [N-2:0]  tw_addr
);

  int         gi;
  logic [N-1:0] cnt;
  logic       en;
  logic       bf;
  logic [N-2:0] tw;

  always_comb begin
    gi  = int'(g);
    cnt = N'(gi - D);
    // Window covers the frame plus one full flush of this stage's delay line.
    en  = run && (gi >= D) && (gi <= D + L + (1 << N) - 1);
    bf  = en && cnt[N-1-S];
    tw  = '0;
    if (S < N - 1 && en && !bf) tw = (N-1)'(cnt) << S;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_en <= 1'b0;
      bf_sel   <= 1'b0;
      tw_addr  <= '0;
    end else begin
      stage_en <= en;
      bf_sel   <= bf;
      tw_addr  <= tw;
    end
  end

endmodule

// File: rtl/r2sdf_fft_ctrl.sv
// Frame sequencer for the radix-2 SDF FFT pipeline; R2SDF_CTRL_BITREV_EN makes
// op_idx the bit-reversed output count (natural frequency order).
module r2sdf_fft_ctrl
  import r2sdf_pkg::*;
#(
  parameter int N        = 4,
  parameter int STG_PIPE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_ip,
  output logic               busy,
  output logic               in_valid,
  output logic [N-1:0]       stage_en,
  output logic [N-1:0]       bf_sel,
  output logic [N*(N-1)-1:0] tw_addr,
  output logic               op_valid,
  output logic [N-1:0]       op_idx,
  output logic               frame_done
);

  localparam int P          = 1 << N;
  localparam int DN         = stage_off(N, N, STG_PIPE);
  localparam int GW         = $clog2(P + DN + 1);
  localparam int LAST_RUN   = P - 1;
  localparam int LAST_DRAIN = DN + P - 1;

  state_t        state;
  state_t        state_nxt;
  logic [GW-1:0] g;
  logic [GW-1:0] g_nxt;
  logic          run_nxt;
  int            gn;
  logic          opv_nxt;
  logic [N-1:0]  idx_raw;
  logic [N-1:0]  idx_nxt;

  // Look ahead one cycle so every registered output matches the g it is shown with.
  always_comb begin
    state_nxt = state;
    g_nxt     = '0;
    run_nxt   = 1'b0;
    case (state)
      IDLE: if (start_ip) begin
        state_nxt = RUN;
        run_nxt   = 1'b1;
      end
      RUN: begin
        g_nxt   = g + 1'b1;
        run_nxt = 1'b1;
        if (g == GW'(LAST_RUN)) state_nxt = DRAIN;
      end
      DRAIN: begin
        g_nxt = g + 1'b1;
        if (g == GW'(LAST_DRAIN)) state_nxt = DONE;
        else                      run_nxt   = 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    gn      = int'(g_nxt);
    opv_nxt = run_nxt && (gn >= DN) && (gn <= LAST_DRAIN);
    idx_raw = N'(gn - DN);
`ifdef R2SDF_CTRL_BITREV_EN
    idx_nxt = N'(bitrev(32'(idx_raw), N));
`else
    idx_nxt = idx_raw;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      g          <= '0;
      busy       <= 1'b0;
      in_valid   <= 1'b0;
      op_valid   <= 1'b0;
      op_idx     <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      g          <= g_nxt;
      busy       <= (state_nxt != IDLE);
      in_valid   <= run_nxt && (gn <= LAST_RUN);
      op_valid   <= opv_nxt;
      op_idx     <= opv_nxt ? idx_nxt : '0;
      frame_done <= (state_nxt == DONE);
    end
  end

  for (genvar s = 0; s < N; s++) begin : g_stage
    r2sdf_stage_seq #(
      .N (N),
      .S (s),
      .D (stage_off(s, N, STG_PIPE)),
      .L (stage_lat(s, N, STG_PIPE)),
      .GW(GW)
    ) u_seq (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (run_nxt),
      .g       (g_nxt),
      .stage_en(stage_en[s]),
      .bf_sel  (bf_sel[s]),
      .tw_addr (tw_addr[s*(N-1) +: N-1])
    );
  end

endmodule
